// File: rtl/operand_fetch_pkg.sv
// Shared widths and the instruction fields that travel alongside the operands
// from operand fetch into execute.
package operand_fetch_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int CNT_W     = 2;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_we;
  } inst_fields_t;

  localparam inst_fields_t INST_FIELDS_RESET = '0;
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register count of writers that have left operand fetch but have not yet
// written back. x0 is never tracked.
module reg_scoreboard #(
  parameter int CNT_W = operand_fetch_pkg::CNT_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clear,
  input  logic                                    inc,
  input  logic [operand_fetch_pkg::REG_IDX_W-1:0] inc_idx,
  input  logic                                    dec,
  input  logic [operand_fetch_pkg::REG_IDX_W-1:0] dec_idx,
  input  logic [operand_fetch_pkg::REG_IDX_W-1:0] rs1_idx,
  input  logic [operand_fetch_pkg::REG_IDX_W-1:0] rs2_idx,
  input  logic [operand_fetch_pkg::REG_IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0]                        rs1_cnt,
  output logic [CNT_W-1:0]                        rs2_cnt,
  output logic [CNT_W-1:0]                        rd_cnt
);
  import operand_fetch_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_hit;
  logic [NUM_REGS-1:0] dec_hit;

  assign rs1_cnt = cnt[rs1_idx];
  assign rs2_cnt = cnt[rs2_idx];
  assign rd_cnt  = cnt[rd_idx];

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    if (inc) inc_hit[inc_idx] = 1'b1;
    if (dec) dec_hit[dec_idx] = 1'b1;
    inc_hit[0] = 1'b0;
    dec_hit[0] = 1'b0;
  end

  // A simultaneous increment and decrement of one register cancels out.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc_hit[i] && !dec_hit[i] && cnt[i] != CNT_MAX)
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec_hit[i] && !inc_hit[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && dec && dec_idx != '0 && !(inc && inc_idx == dec_idx))
      assert (cnt[dec_idx] != '0)
        else $error("reg_scoreboard: writeback to x%0d with no pending writer", dec_idx);
  end
endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: RAW hazard check against the pending-writer scoreboard,
// writeback bypass onto the operands, and a one-entry output register to execute.
module operand_fetch #(
  parameter int XLEN  = operand_fetch_pkg::XLEN,
  parameter int CNT_W = operand_fetch_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic            in_rs1_use,
  input  logic            in_rs2_use,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_imm,
  output logic [4:0]      raddr0,
  output logic [4:0]      raddr1,
  input  logic [XLEN-1:0] rdata0,
  input  logic [XLEN-1:0] rdata1,
  input  logic            wb_we,
  input  logic [4:0]      wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [31:0]     out_pc,
  output logic [31:0]     out_imm
);
  import operand_fetch_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic             rs1_live, rs2_live;
  logic             rs1_wb_hit, rs2_wb_hit;
  logic             rs1_haz, rs2_haz;
  logic             rd_dec, struct_stall;
  logic             accept, handoff;
  logic             sb_inc, sb_dec;
  logic [XLEN-1:0]  rs1_val, rs2_val;
  inst_fields_t     fields_q;

  assign raddr0 = in_rs1;
  assign raddr1 = in_rs2;

  assign rs1_live   = in_rs1_use && (in_rs1 != '0);
  assign rs2_live   = in_rs2_use && (in_rs2 != '0);
  assign rs1_wb_hit = wb_we && (wb_waddr == in_rs1) && (in_rs1 != '0);
  assign rs2_wb_hit = wb_we && (wb_waddr == in_rs2) && (in_rs2 != '0);

  // One pending writer is fine only if it is writing back right now.
  assign rs1_haz = rs1_live && ((out_valid && out_rd_we && out_rd == in_rs1) ||
                                (rs1_cnt > CNT_ONE) ||
                                (rs1_cnt == CNT_ONE && !rs1_wb_hit));
  assign rs2_haz = rs2_live && ((out_valid && out_rd_we && out_rd == in_rs2) ||
                                (rs2_cnt > CNT_ONE) ||
                                (rs2_cnt == CNT_ONE && !rs2_wb_hit));

  assign rd_dec       = wb_we && (wb_waddr == in_rd);
  assign struct_stall = in_rd_we && (in_rd != '0) && (rd_cnt == CNT_MAX) && !rd_dec;

  assign in_ready = !flush && (!out_valid || out_ready) && !rs1_haz && !rs2_haz && !struct_stall;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready && !flush;

  assign rs1_val = !rs1_live ? '0 : rs1_wb_hit ? wb_wdata : rdata0;
  assign rs2_val = !rs2_live ? '0 : rs2_wb_hit ? wb_wdata : rdata1;

  assign sb_inc = handoff && out_rd_we && (out_rd != '0);
  assign sb_dec = wb_we && (wb_waddr != '0) && !flush;

  reg_scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .inc     (sb_inc),
    .inc_idx (out_rd),
    .dec     (sb_dec),
    .dec_idx (wb_waddr),
    .rs1_idx (in_rs1),
    .rs2_idx (in_rs2),
    .rd_idx  (in_rd),
    .rs1_cnt (rs1_cnt),
    .rs2_cnt (rs2_cnt),
    .rd_cnt  (rd_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      fields_q    <= INST_FIELDS_RESET;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_rs1_val <= rs1_val;
      out_rs2_val <= rs2_val;
      fields_q    <= '{pc: in_pc, imm: in_imm, rd: in_rd, rd_we: in_rd_we};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc    = fields_q.pc;
  assign out_imm   = fields_q.imm;
  assign out_rd    = fields_q.rd;
  assign out_rd_we = fields_q.rd_we;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a behavioural model of the stage is compared
// against the DUT every cycle, plus hand-computed checks at key points.
module tb_operand_fetch;
  localparam int PEND_MAX = (1 << 2) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rs1_use, in_rs2_use, in_rd_we;
  logic [31:0] in_pc, in_imm;
  logic [4:0]  raddr0, raddr1;
  logic [31:0] rdata0, rdata1;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_pc, out_imm;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_pc(in_pc), .in_imm(in_imm),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc), .out_imm(out_imm)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit live   = 1'b0;

  // Model state: the entry execute sees, and writers outstanding per register.
  bit          m_valid;
  logic [31:0] m_rs1v, m_rs2v, m_pc, m_imm;
  logic [4:0]  m_rd;
  bit          m_rd_we;
  int          m_pend [32];
  bit          m_acc, m_ho;
  logic [31:0] m_v1, m_v2;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Writers still unresolved for a source: those in flight that are not
  // writing back this cycle, plus one still sitting in the output entry.
  function automatic int outstanding(logic [4:0] r);
    int n;
    n = m_pend[r] - ((wb_we && wb_waddr == r) ? 1 : 0);
    if (n < 0) n = 0;
    if (m_valid && m_rd_we && m_rd == r) n++;
    return n;
  endfunction

  function automatic bit exp_ready();
    bit ok;
    ok = !flush && (!m_valid || out_ready);
    if (in_rs1_use && in_rs1 != 5'd0 && outstanding(in_rs1) > 0) ok = 1'b0;
    if (in_rs2_use && in_rs2 != 5'd0 && outstanding(in_rs2) > 0) ok = 1'b0;
    if (in_rd_we && in_rd != 5'd0 &&
        m_pend[in_rd] - ((wb_we && wb_waddr == in_rd) ? 1 : 0) >= PEND_MAX) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] exp_operand(logic [4:0] r, bit u, logic [31:0] rf);
    if (!u || r == 5'd0) return 32'd0;
    if (wb_we && wb_waddr == r) return wb_wdata;
    return rf;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      live = 1'b1;
      m_valid = 1'b0; m_rs1v = 0; m_rs2v = 0; m_pc = 0; m_imm = 0; m_rd = 0; m_rd_we = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else if (flush) begin
      m_valid = 1'b0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      m_acc = in_valid && exp_ready();
      m_v1  = exp_operand(in_rs1, in_rs1_use, rdata0);
      m_v2  = exp_operand(in_rs2, in_rs2_use, rdata1);
      m_ho  = m_valid && out_ready;
      if (m_ho && m_rd_we && m_rd != 5'd0) m_pend[m_rd] += 1;
      if (wb_we && wb_waddr != 5'd0) m_pend[wb_waddr] -= 1;
      foreach (m_pend[i]) begin
        if (m_pend[i] < 0) m_pend[i] = 0;
        if (m_pend[i] > PEND_MAX) m_pend[i] = PEND_MAX;
      end
      if (m_acc) begin
        m_valid = 1'b1; m_rs1v = m_v1; m_rs2v = m_v2;
        m_pc = in_pc; m_imm = in_imm; m_rd = in_rd; m_rd_we = in_rd_we;
      end else if (m_ho) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (live && !rst) begin
      checkOutput("cyc_in_ready", in_ready, exp_ready());
      checkOutput("cyc_raddr0", raddr0, in_rs1);
      checkOutput("cyc_raddr1", raddr1, in_rs2);
      checkOutput("cyc_out_valid", out_valid, m_valid);
      if (m_valid) begin
        checkOutput("cyc_rs1_val", out_rs1_val, m_rs1v);
        checkOutput("cyc_rs2_val", out_rs2_val, m_rs2v);
        checkOutput("cyc_rd", out_rd, m_rd);
        checkOutput("cyc_rd_we", out_rd_we, m_rd_we);
        checkOutput("cyc_pc", out_pc, m_pc);
        checkOutput("cyc_imm", out_imm, m_imm);
      end
    end
  end

  task automatic applyStimulus(bit v, logic [4:0] rs1, bit u1, logic [4:0] rs2, bit u2,
                               logic [4:0] rd, bit we, logic [31:0] pc);
    in_valid = v; in_rs1 = rs1; in_rs1_use = u1; in_rs2 = rs2; in_rs2_use = u2;
    in_rd = rd; in_rd_we = we; in_pc = pc; in_imm = ~pc;
  endtask

  task automatic clockCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0; rdata0 = 32'd0; rdata1 = 32'd0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) clockCycle();
    rst = 1'b0; #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_pc", out_pc, 0);
    checkOutput("reset_out_rs1", out_rs1_val, 0);
    checkOutput("reset_in_ready", in_ready, 1);

    // Basic pass
    applyStimulus(1, 3, 1, 4, 1, 0, 0, 32'h100);
    rdata0 = 32'h11; rdata1 = 32'h22; #1;
    checkOutput("basic_raddr0", raddr0, 3);
    checkOutput("basic_raddr1", raddr1, 4);
    checkOutput("basic_in_ready", in_ready, 1);
    clockCycle();
    in_valid = 1'b0; #1;
    checkOutput("basic_out_valid", out_valid, 1);
    checkOutput("basic_rs1_val", out_rs1_val, 32'h11);
    checkOutput("basic_rs2_val", out_rs2_val, 32'h22);
    checkOutput("basic_pc", out_pc, 32'h100);
    checkOutput("basic_ready_after", in_ready, 1);
    clockCycle();

    // Back-to-back RAW on x5
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 32'h200);
    clockCycle();
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 32'h204);
    rdata0 = 32'h1234; #1;
    checkOutput("raw_held_stall", in_ready, 0);
    clockCycle();
    #1;
    checkOutput("raw_pending_stall", in_ready, 0);
    checkOutput("raw_out_drained", out_valid, 0);
    clockCycle();
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hDEAD; #1;
    checkOutput("raw_bypass_ready", in_ready, 1);
    clockCycle();
    wb_we = 1'b0; in_valid = 1'b0; #1;
    checkOutput("raw_bypass_value", out_rs1_val, 32'hDEAD);
    checkOutput("raw_pc", out_pc, 32'h204);
    clockCycle();

    // x0 and unused sources, writeback to x0
    applyStimulus(1, 0, 1, 8, 0, 0, 1, 32'h300);
    rdata0 = 32'hAAAA; rdata1 = 32'hBBBB;
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF; #1;
    checkOutput("x0_in_ready", in_ready, 1);
    clockCycle();
    applyStimulus(1, 0, 1, 8, 0, 0, 1, 32'h304); #1;
    checkOutput("x0_held_ready", in_ready, 1);
    checkOutput("x0_rs1_zero", out_rs1_val, 0);
    checkOutput("x0_rs2_zero", out_rs2_val, 0);
    clockCycle();
    wb_we = 1'b0; in_valid = 1'b0;
    clockCycle();

    // Backpressure
    out_ready = 1'b0;
    applyStimulus(1, 1, 1, 2, 1, 0, 0, 32'h400);
    rdata0 = 32'h31; rdata1 = 32'h32;
    clockCycle();
    applyStimulus(1, 2, 1, 1, 1, 0, 0, 32'h404);
    rdata0 = 32'h41; rdata1 = 32'h42;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_pc", out_pc, 32'h400);
      checkOutput("bp_rs1_val", out_rs1_val, 32'h31);
      clockCycle();
    end
    out_ready = 1'b1; #1;
    checkOutput("bp_release_ready", in_ready, 1);
    clockCycle();
    in_valid = 1'b0; #1;
    checkOutput("bp_next_pc", out_pc, 32'h404);
    checkOutput("bp_next_rs1", out_rs1_val, 32'h41);
    checkOutput("bp_next_rs2", out_rs2_val, 32'h42);
    clockCycle();

    // Saturation of x7 and simultaneous inc/dec
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 7, 1, 32'h500 + 32'(4 * i));
      clockCycle();
    end
    in_valid = 1'b0;
    clockCycle();
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 32'h50C); #1;
    checkOutput("sat_writer_stall", in_ready, 0);
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h70; #1;
    checkOutput("sat_dec_frees_slot", in_ready, 1);
    clockCycle();
    in_valid = 1'b0;
    clockCycle();
    applyStimulus(1, 7, 1, 0, 0, 0, 0, 32'h510);
    rdata0 = 32'h1111; wb_wdata = 32'h71; #1;
    checkOutput("incdec_two_left", in_ready, 0);
    clockCycle();
    wb_wdata = 32'h72; #1;
    checkOutput("incdec_last_wb_ready", in_ready, 1);
    clockCycle();
    wb_we = 1'b0; in_valid = 1'b0; #1;
    checkOutput("incdec_bypass_val", out_rs1_val, 32'h72);
    clockCycle();

    // Flush with pending[9]=2 and an entry held
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 9, 1, 32'h600 + 32'(4 * i));
      clockCycle();
    end
    out_ready = 1'b0;
    applyStimulus(1, 9, 1, 0, 0, 0, 0, 32'h610);
    rdata0 = 32'h99; flush = 1'b1; #1;
    checkOutput("flush_blocks_accept", in_ready, 0);
    clockCycle();
    flush = 1'b0; #1;
    checkOutput("flush_out_valid", out_valid, 0);
    checkOutput("flush_reader_ready", in_ready, 1);
    clockCycle();
    in_valid = 1'b0; #1;
    checkOutput("flush_reader_val", out_rs1_val, 32'h99);
    checkOutput("flush_reader_pc", out_pc, 32'h610);
    out_ready = 1'b1;
    clockCycle();

    // Reset in the middle of a stall
    applyStimulus(1, 0, 0, 0, 0, 12, 1, 32'h700);
    clockCycle();
    applyStimulus(1, 0, 0, 0, 0, 13, 1, 32'h704);
    clockCycle();
    out_ready = 1'b0;
    applyStimulus(1, 12, 1, 0, 0, 0, 0, 32'h708); #1;
    checkOutput("rst_pre_stall", in_ready, 0);
    rst = 1'b1;
    clockCycle();
    rst = 1'b0; #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_pc", out_pc, 0);
    checkOutput("rst_reader_ready", in_ready, 1);
    clockCycle();
    in_valid = 1'b0; out_ready = 1'b1; #1;
    checkOutput("rst_reader_pc", out_pc, 32'h708);
    clockCycle();
    clockCycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
